// File: rtl/node_cfg_pkg.sv
// Shared definitions for the node configuration command path:
// opcodes, header field placement, response tag and controller states.
package node_cfg_pkg;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_RD  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    // The opcode sits in the top OP_W bits; the len-1 field starts right below it.
    localparam int OP_W        = 2;
    localparam int LEN_TOP_GAP = OP_W;

    localparam logic [1:0] RSP_TAG = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ISS,
        RD_WAIT,
        RD_OUT
    } state_e;

endpackage

// File: rtl/config_ctrl.sv
// Command front-end of the node configurator: turns single/burst command flits
// into registered config write/read strobes and returns read data as response flits.
module config_ctrl
    import node_cfg_pkg::*;
#(
    parameter int CDW = 21,
    parameter int CAW = 15,
    parameter int ATW = 3,
    parameter int FLW = 24,
    parameter int LW  = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [FLW-1:0] cmd_flit,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [FLW-1:0] rsp_flit,
    output logic           config_we,
    output logic [CAW-1:0] config_waddr,
    output logic [CDW-1:0] config_wdata,
    output logic           config_re,
    output logic [CAW-1:0] config_raddr,
    input  logic [CDW-1:0] config_rdata,
    output logic           busy,
    output logic           err_op
);

    localparam int LOW_W  = CAW - ATW;
    localparam int LEN_HI = FLW - 1 - LEN_TOP_GAP;
    localparam logic [LOW_W-1:0] LOW_ONE = LOW_W'(1);
    localparam logic [LW-1:0]    CNT_ONE = LW'(1);

    state_e         state_q;
    logic [CAW-1:0] addr_q;
    logic [LW-1:0]  cnt_q;
    logic           we_q;
    logic [CAW-1:0] waddr_q;
    logic [CDW-1:0] wdata_q;
    logic           re_q;
    logic [CAW-1:0] raddr_q;
    logic           rsp_valid_q;
    logic [FLW-1:0] rsp_flit_q;
    logic [FLW-1:0] rsp_flit_d;
    logic           err_q;

    logic [1:0]     hdr_op;
    logic [LW-1:0]  hdr_len;
    logic [CAW-1:0] hdr_addr;
    logic           cmd_fire;

    // Bursts walk only the low address bits so they never leave their region.
    function automatic logic [CAW-1:0] region_inc(input logic [CAW-1:0] a);
        return {a[CAW-1:LOW_W], a[LOW_W-1:0] + LOW_ONE};
    endfunction

    assign hdr_op   = cmd_flit[FLW-1 -: OP_W];
    assign hdr_len  = cmd_flit[LEN_HI -: LW];
    assign hdr_addr = cmd_flit[CAW-1:0];

    assign cmd_ready = (state_q == IDLE) || (state_q == WR);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign busy      = (state_q != IDLE);

    always_comb begin
        rsp_flit_d               = '0;
        rsp_flit_d[FLW-1 -: 2]   = RSP_TAG;
        rsp_flit_d[CDW-1:0]      = config_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            re_q        <= 1'b0;
            raddr_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_flit_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            we_q  <= 1'b0;
            re_q  <= 1'b0;
            err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cmd_fire) begin
                        unique case (hdr_op)
                            OP_WR: begin
                                addr_q  <= hdr_addr;
                                cnt_q   <= hdr_len;
                                state_q <= WR;
                            end
                            OP_RD: begin
                                addr_q  <= hdr_addr;
                                cnt_q   <= hdr_len;
                                re_q    <= 1'b1;
                                raddr_q <= hdr_addr;
                                state_q <= RD_ISS;
                            end
                            OP_ILL:  err_q <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                WR: begin
                    if (cmd_fire) begin
                        we_q    <= 1'b1;
                        waddr_q <= addr_q;
                        wdata_q <= cmd_flit[CDW-1:0];
                        addr_q  <= region_inc(addr_q);
                        if (cnt_q == '0) begin
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end
                    end
                end
                RD_ISS: state_q <= RD_WAIT;
                RD_WAIT: begin
                    rsp_flit_q  <= rsp_flit_d;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RD_OUT;
                end
                RD_OUT: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (cnt_q == '0) begin
                            state_q <= IDLE;
                        end else begin
                            addr_q  <= region_inc(addr_q);
                            cnt_q   <= cnt_q - CNT_ONE;
                            re_q    <= 1'b1;
                            raddr_q <= region_inc(addr_q);
                            state_q <= RD_ISS;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign config_we    = we_q;
    assign config_waddr = waddr_q;
    assign config_wdata = wdata_q;
    assign config_re    = re_q;
    assign config_raddr = raddr_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_flit     = rsp_flit_q;
    assign err_op       = err_q;

endmodule

// File: tb/tb_config_ctrl.sv
// Self-checking bench for config_ctrl: directed scenarios plus randomized command
// streams checked against a transaction-level model of the configuration path.
module tb_config_ctrl;

    localparam int CDW = 21;
    localparam int CAW = 15;
    localparam int ATW = 3;
    localparam int FLW = 24;
    localparam int LW  = 4;
    localparam int LOWMASK  = (1 << (CAW - ATW)) - 1;
    localparam int ADDRMASK = (1 << CAW) - 1;
    localparam int DATAMASK = (1 << CDW) - 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [FLW-1:0] cmd_flit = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [FLW-1:0] rsp_flit;
    logic           config_we;
    logic [CAW-1:0] config_waddr;
    logic [CDW-1:0] config_wdata;
    logic           config_re;
    logic [CAW-1:0] config_raddr;
    logic [CDW-1:0] config_rdata = '0;
    logic           busy;
    logic           err_op;

    config_ctrl #(.CDW(CDW), .CAW(CAW), .ATW(ATW), .FLW(FLW), .LW(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_flit(cmd_flit),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_flit(rsp_flit),
        .config_we(config_we), .config_waddr(config_waddr), .config_wdata(config_wdata),
        .config_re(config_re), .config_raddr(config_raddr), .config_rdata(config_rdata),
        .busy(busy), .err_op(err_op)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int bothHigh = 0;
    int unstable = 0;
    int weAddrQ[$], weDataQ[$], weCycQ[$], reAddrQ[$], reCycQ[$], errCycQ[$], rspQ[$];
    int expWeAddrQ[$], expWeDataQ[$], expReAddrQ[$], expRspQ[$], planQ[$];
    logic prevRe = 1'b0;
    logic prevHold = 1'b0;
    logic [FLW-1:0] prevFlit = '0;
    int pendData = 0;

    function automatic int hdr(input int op, input int lenm1, input int addr, input int junk);
        return (op << (FLW - 2)) | (lenm1 << (FLW - 2 - LW)) | ((junk & 7) << CAW) | (addr & ADDRMASK);
    endfunction

    // Address of beat i of a burst: region bits fixed, low bits wrap.
    function automatic int expAddr(input int base, input int i);
        return (base & ADDRMASK & ~LOWMASK) | ((base + i) & LOWMASK);
    endfunction

    task automatic checkOutput(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    // One clock: record handshakes/strobes seen by the configurator and play the memory.
    task automatic tick();
        if (rsp_valid && rsp_ready) rspQ.push_back(int'(rsp_flit));
        prevHold = rsp_valid && !rsp_ready;
        prevFlit = rsp_flit;
        @(posedge clk);
        #1;
        cyc++;
        if (prevHold && rst_n && (!rsp_valid || rsp_flit !== prevFlit)) unstable++;
        if (config_we) begin
            weAddrQ.push_back(int'(config_waddr));
            weDataQ.push_back(int'(config_wdata));
            weCycQ.push_back(cyc);
        end
        if (config_re) begin
            reAddrQ.push_back(int'(config_raddr));
            reCycQ.push_back(cyc);
        end
        if (config_we && config_re) bothHigh++;
        if (err_op) errCycQ.push_back(cyc);
        if (prevRe) config_rdata = CDW'(pendData);
        else        config_rdata = CDW'($urandom);
        prevRe = config_re;
        if (config_re) begin
            pendData = (planQ.size() > 0) ? planQ.pop_front() : int'($urandom_range(0, DATAMASK));
            expRspQ.push_back((2 << (FLW - 2)) | pendData);
        end
    endtask

    task automatic applyStimulus(input int flit, output int stamp, output int waited);
        logic rdy;
        cmd_valid = 1'b1;
        cmd_flit  = FLW'(flit);
        waited = 0;
        stamp = -1;
        while (waited < 50) begin
            rdy = cmd_ready;
            waited++;
            tick();
            if (rdy) begin
                stamp = cyc;
                break;
            end
        end
        cmd_valid = 1'b0;
        cmd_flit  = FLW'($urandom);
        if (stamp < 0) checkOutput("cmd_accept_timeout", 0, 1);
    endtask

    task automatic doWrite(input int addr, input int n, input int firstData, input int gapMax,
                           output int hdrStamp, output int hdrWait);
        int s, w, d;
        applyStimulus(hdr(1, n - 1, addr, $urandom), hdrStamp, hdrWait);
        for (int i = 0; i < n; i++) begin
            if (gapMax > 0) repeat ($urandom_range(0, gapMax)) tick();
            d = (firstData >= 0) ? firstData + i : int'($urandom_range(0, DATAMASK));
            expWeAddrQ.push_back(expAddr(addr, i));
            expWeDataQ.push_back(d);
            applyStimulus(d | (int'($urandom_range(0, 7)) << CDW), s, w);
        end
    endtask

    task automatic verifyWrites();
        checkOutput("we_count", weAddrQ.size(), expWeAddrQ.size());
        for (int i = 0; i < expWeAddrQ.size(); i++) begin
            checkOutput("we_addr", (i < weAddrQ.size()) ? weAddrQ[i] : -1, expWeAddrQ[i]);
            checkOutput("we_data", (i < weDataQ.size()) ? weDataQ[i] : -1, expWeDataQ[i]);
        end
        weAddrQ.delete(); weDataQ.delete(); weCycQ.delete();
        expWeAddrQ.delete(); expWeDataQ.delete();
    endtask

    task automatic doRead(input int addr, input int n, input int holdFirst, input int bpRand,
                          output int hdrStamp, output logic sawReady);
        int w, hold, guard;
        hold = 0;
        guard = 0;
        sawReady = 1'b0;
        for (int i = 0; i < n; i++) expReAddrQ.push_back(expAddr(addr, i));
        applyStimulus(hdr(2, n - 1, addr, $urandom), hdrStamp, w);
        while (rspQ.size() < n && guard < 500) begin
            if (rsp_valid && rspQ.size() == 0 && hold < holdFirst) begin
                rsp_ready = 1'b0;
                hold++;
            end else if (bpRand != 0) begin
                rsp_ready = 1'($urandom_range(0, 1));
            end else begin
                rsp_ready = 1'b1;
            end
            if (cmd_ready) sawReady = 1'b1;
            tick();
            guard++;
        end
        rsp_ready = 1'b0;
    endtask

    task automatic verifyReads();
        checkOutput("re_count", reAddrQ.size(), expReAddrQ.size());
        checkOutput("rsp_count", rspQ.size(), expRspQ.size());
        for (int i = 0; i < expReAddrQ.size(); i++)
            checkOutput("re_addr", (i < reAddrQ.size()) ? reAddrQ[i] : -1, expReAddrQ[i]);
        for (int i = 0; i < expRspQ.size(); i++)
            checkOutput("rsp_flit", (i < rspQ.size()) ? rspQ[i] : -1, expRspQ[i]);
        reAddrQ.delete(); reCycQ.delete(); rspQ.delete();
        expReAddrQ.delete(); expRspQ.delete();
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_we"}, int'(config_we), 0);
        checkOutput({tag, "_re"}, int'(config_re), 0);
        checkOutput({tag, "_rsp_valid"}, int'(rsp_valid), 0);
        checkOutput({tag, "_err_op"}, int'(err_op), 0);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_cmd_ready"}, int'(cmd_ready), 1);
        checkOutput({tag, "_waddr"}, int'(config_waddr), 0);
        checkOutput({tag, "_wdata"}, int'(config_wdata), 0);
        checkOutput({tag, "_raddr"}, int'(config_raddr), 0);
        checkOutput({tag, "_rsp_flit"}, int'(rsp_flit), 0);
    endtask

    initial begin
        int hs, hw, s, w, op, n, a;
        logic sawReady;

        // Power-on reset
        repeat (3) tick();
        checkResetOutputs("reset");
        rst_n = 1'b1;
        repeat (2) tick();

        // Single write
        doWrite('h0001, 1, 'h00005, 0, hs, hw);
        checkOutput("single_we_cycle", (weCycQ.size() > 0) ? weCycQ[0] : -1, hs + 1);
        verifyWrites();
        tick();
        checkOutput("single_back_idle", int'(busy), 0);

        // Burst write with region wrap, back-to-back data
        doWrite('h2FFE, 4, 1, 0, hs, hw);
        for (int i = 1; i < 4; i++)
            checkOutput("burst_consecutive", (weCycQ.size() > i) ? weCycQ[i] - weCycQ[0] : -1, i);
        verifyWrites();

        // Read burst with back-pressure on beat 0
        planQ.push_back('h0ABCD);
        planQ.push_back('h01234);
        doRead('h4003, 2, 5, 0, hs, sawReady);
        checkOutput("rd_cmd_ready_low", int'(sawReady), 0);
        checkOutput("rd_beat0_flit", (rspQ.size() > 0) ? rspQ[0] : -1, int'({2'b10, 1'b0, 21'h0ABCD}));
        checkOutput("rd_hold_stable", unstable, 0);
        verifyReads();

        // Read timing with the sink always ready
        doRead('h1FFF, 3, 0, 0, hs, sawReady);
        checkOutput("rd_first_re_cycle", (reCycQ.size() > 0) ? reCycQ[0] : -1, hs);
        checkOutput("rd_re_spacing", (reCycQ.size() > 1) ? reCycQ[1] - reCycQ[0] : -1, 3);
        verifyReads();

        // Illegal then nop opcode, then an immediate write
        errCycQ.delete();
        applyStimulus(hdr(3, $urandom_range(0, 15), $urandom, $urandom), hs, w);
        tick();
        tick();
        checkOutput("err_pulse_count", errCycQ.size(), 1);
        checkOutput("err_pulse_cycle", (errCycQ.size() > 0) ? errCycQ[0] : -1, hs);
        checkOutput("err_no_we", weAddrQ.size(), 0);
        checkOutput("err_no_re", reAddrQ.size(), 0);
        checkOutput("err_idle", int'(busy), 0);
        applyStimulus(hdr(0, $urandom_range(0, 15), $urandom, $urandom), hs, w);
        doWrite('h3456, 2, -1, 0, s, hw);
        checkOutput("nop_then_wr_accept", hw, 1);
        checkOutput("nop_no_err", errCycQ.size(), 1);
        verifyWrites();

        // Reset in the middle of a 4-beat write
        applyStimulus(hdr(1, 3, 'h0100, 0), hs, w);
        for (int i = 0; i < 2; i++) begin
            expWeAddrQ.push_back(expAddr('h0100, i));
            expWeDataQ.push_back('h100 + i);
            applyStimulus('h100 + i, s, w);
        end
        rst_n = 1'b0;
        repeat (2) tick();
        checkResetOutputs("midreset");
        rst_n = 1'b1;
        repeat (3) tick();
        checkOutput("midreset_idle", int'(busy), 0);
        verifyWrites();
        doWrite('h0200, 1, 'h1ABCDE, 0, hs, hw);
        verifyWrites();

        // Randomized command stream
        for (int k = 0; k < 30; k++) begin
            op = $urandom_range(0, 9);
            n  = $urandom_range(1, 1 << LW);
            a  = $urandom_range(0, ADDRMASK);
            if (op < 5) begin
                doWrite(a, n, -1, 2, hs, hw);
                verifyWrites();
            end else if (op < 9) begin
                doRead(a, n, 0, 1, hs, sawReady);
                checkOutput("rand_rd_cmd_ready_low", int'(sawReady), 0);
                verifyReads();
            end else begin
                applyStimulus(hdr(0, n - 1, a, $urandom), hs, w);
                tick();
                checkOutput("rand_nop_idle", int'(busy), 0);
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        checkOutput("we_re_exclusive", bothHigh, 0);
        checkOutput("rsp_stable_under_backpressure", unstable, 0);
        checkOutput("no_spurious_err", errCycQ.size(), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
